// File: rtl/vga_driver.sv
// rtl/vga_driver.sv - 640x480@60 single-box VGA demo driven by four push-buttons.
// Build macro DRIVER_DEBOUNCE_EN compiles in the per-button stability counter.

module vga_btn_cond #(
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic rst_n,
   input  logic btn,
   output logic press
);
   logic sync1;
   logic sync2;
   logic level;
   logic level_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1 <= 1'b0;
         sync2 <= 1'b0;
      end else begin
         sync1 <= btn;
         sync2 <= sync1;
      end
   end

`ifdef DRIVER_DEBOUNCE_EN
   localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;

   typedef enum logic {
      RELEASED = 1'b0,
      PRESSED  = 1'b1
   } db_state_t;

   db_state_t     state;
   db_state_t     state_next;
   logic [CW-1:0] count;
   logic [CW-1:0] count_next;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= RELEASED;
         count <= '0;
      end else begin
         state <= state_next;
         count <= count_next;
      end
   end

   // Any return to the accepted level restarts the stability count.
   always_comb begin
      state_next = state;
      count_next = count;
      if (sync2 == (state == PRESSED)) begin
         count_next = '0;
      end else if (count == CW'(DEBOUNCE_CYCLES - 1)) begin
         count_next = '0;
         state_next = (state == PRESSED) ? RELEASED : PRESSED;
      end else begin
         count_next = count + 1'b1;
      end
   end

   assign level = (state == PRESSED);
`else
   logic unused_cfg;
   assign unused_cfg = (DEBOUNCE_CYCLES > 0);
   assign level      = sync2;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         level_q <= 1'b0;
      end else begin
         level_q <= level;
      end
   end

   assign press = level & ~level_q;
endmodule

module vga_driver #(
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int STEP            = 16,
   parameter int BOX_W           = 64,
   parameter int BOX_H           = 64,
   parameter int BOX_Y           = 400
) (
   input  logic       clk,
   input  logic       sw,
   input  logic       btnR,
   input  logic       btnL,
   input  logic       btnM,
   input  logic       btnT,
   output logic [2:0] vgaRed,
   output logic [2:0] vgaGreen,
   output logic [1:0] vgaBlue,
   output logic       Hsync,
   output logic       Vsync
);
   localparam int H_VIS    = 640;
   localparam int H_SYNC_S = 656;
   localparam int H_SYNC_E = 751;
   localparam int H_TOTAL  = 800;
   localparam int V_VIS    = 480;
   localparam int V_SYNC_S = 490;
   localparam int V_SYNC_E = 491;
   localparam int V_TOTAL  = 525;
   localparam int X_MAX    = H_VIS - BOX_W;
   localparam int X_CENTRE = X_MAX / 2;

   logic       rst_n;
   logic [1:0] div;
   logic       tick;
   logic [9:0] hcount;
   logic [9:0] vcount;
   logic [9:0] box_x;
   logic [9:0] box_x_next;
   logic [1:0] colour_idx;
   logic       press_r;
   logic       press_l;
   logic       press_m;
   logic       press_t;
   logic       visible;
   logic       in_x;
   logic       in_y;
   logic       hsync_next;
   logic       vsync_next;
   logic [7:0] box_rgb;
   logic [7:0] rgb_next;

   assign rst_n = sw;

   vga_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_r (
      .clk(clk), .rst_n(rst_n), .btn(btnR), .press(press_r));
   vga_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_l (
      .clk(clk), .rst_n(rst_n), .btn(btnL), .press(press_l));
   vga_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_m (
      .clk(clk), .rst_n(rst_n), .btn(btnM), .press(press_m));
   vga_btn_cond #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_t (
      .clk(clk), .rst_n(rst_n), .btn(btnT), .press(press_t));

   // Tick on the last divider phase so hcount reaches 656 exactly 656*4 clk after reset.
   assign tick = (div == 2'd3);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         div    <= '0;
         hcount <= '0;
         vcount <= '0;
      end else begin
         div <= div + 2'd1;
         if (tick) begin
            if (hcount == 10'(H_TOTAL - 1)) begin
               hcount <= '0;
               if (vcount == 10'(V_TOTAL - 1)) begin
                  vcount <= '0;
               end else begin
                  vcount <= vcount + 10'd1;
               end
            end else begin
               hcount <= hcount + 10'd1;
            end
         end
      end
   end

   always_comb begin
      box_x_next = box_x;
      if (press_m) begin
         box_x_next = 10'(X_CENTRE);
      end else if (!(press_r && press_l)) begin
         if (press_r) begin
            box_x_next = (box_x >= 10'(X_MAX - STEP)) ? 10'(X_MAX) : box_x + 10'(STEP);
         end else if (press_l) begin
            box_x_next = (box_x <= 10'(STEP)) ? 10'd0 : box_x - 10'(STEP);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         box_x      <= 10'(X_CENTRE);
         colour_idx <= '0;
      end else begin
         box_x <= box_x_next;
         if (press_t) begin
            colour_idx <= colour_idx + 2'd1;
         end
      end
   end

   always_comb begin
      box_rgb = 8'h00;
      case (colour_idx)
         2'd0:    box_rgb = {3'd7, 3'd0, 2'd0};
         2'd1:    box_rgb = {3'd0, 3'd7, 2'd0};
         2'd2:    box_rgb = {3'd0, 3'd0, 2'd3};
         default: box_rgb = {3'd7, 3'd7, 2'd3};
      endcase
   end

   always_comb begin
      visible    = (hcount < 10'(H_VIS)) && (vcount < 10'(V_VIS));
      in_x       = (hcount >= box_x) && ({1'b0, hcount} < ({1'b0, box_x} + 11'(BOX_W)));
      in_y       = (vcount >= 10'(BOX_Y)) && ({1'b0, vcount} < 11'(BOX_Y + BOX_H));
      hsync_next = !((hcount >= 10'(H_SYNC_S)) && (hcount <= 10'(H_SYNC_E)));
      vsync_next = !((vcount >= 10'(V_SYNC_S)) && (vcount <= 10'(V_SYNC_E)));
      rgb_next   = (visible && in_x && in_y) ? box_rgb : 8'h00;
   end

   // All pins are registered together so sync and colour stay aligned.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         Hsync    <= 1'b1;
         Vsync    <= 1'b1;
         vgaRed   <= '0;
         vgaGreen <= '0;
         vgaBlue  <= '0;
      end else begin
         Hsync    <= hsync_next;
         Vsync    <= vsync_next;
         vgaRed   <= rgb_next[7:5];
         vgaGreen <= rgb_next[4:2];
         vgaBlue  <= rgb_next[1:0];
      end
   end
endmodule

// File: tb/tb_vga_driver.sv
// tb/tb_vga_driver.sv - self-checking bench for vga_driver (timing, moves, colours, reset).

module tb_vga_driver;
   logic       clk;
   logic       sw;
   logic       btnR;
   logic       btnL;
   logic       btnM;
   logic       btnT;
   logic [2:0] vgaRed;
   logic [2:0] vgaGreen;
   logic [1:0] vgaBlue;
   logic       Hsync;
   logic       Vsync;
   logic [7:0] rgb;

   int checks   = 0;
   int failures = 0;
   int ecount   = 0;
   bit counting = 0;

   vga_driver #(
      .DEBOUNCE_CYCLES(8),
      .STEP(16),
      .BOX_W(64),
      .BOX_H(478),
      .BOX_Y(2)
   ) dut (
      .clk(clk),
      .sw(sw),
      .btnR(btnR),
      .btnL(btnL),
      .btnM(btnM),
      .btnT(btnT),
      .vgaRed(vgaRed),
      .vgaGreen(vgaGreen),
      .vgaBlue(vgaBlue),
      .Hsync(Hsync),
      .Vsync(Vsync)
   );

   assign rgb = {vgaRed, vgaGreen, vgaBlue};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Edge number since reset release; outputs after edge e show pixel floor((e-1)/4).
   always @(posedge clk) if (counting) ecount <= ecount + 1;

   typedef struct {
      logic r;
      logic l;
      logic m;
      logic t;
      int   x;
      int   col;
   } vec_t;

   vec_t vecs[13];

   function automatic logic [7:0] col_rgb(input int c);
      case (c)
         0:       return 8'hE0;
         1:       return 8'h1C;
         2:       return 8'h03;
         default: return 8'hFF;
      endcase
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic wait_edge(input int target);
      while (ecount < target) @(negedge clk);
   endtask

   task automatic check_pixel(input string name, input int x, input int line_min,
                              input logic [7:0] exp);
      int line;
      int target;
      line = line_min;
      while (3200 * line + 4 * x + 1 <= ecount) line++;
      target = 3200 * line + 4 * x + 1;
      if (line >= 480) begin
         checks++;
         failures++;
         $display("FAIL %s: no visible line left, line %0d", name, line);
      end else begin
         wait_edge(target);
         chk(name, rgb, exp);
      end
   endtask

   task automatic check_box(input string name, input int x, input int col);
      if (x > 0) check_pixel({name, "_left_out"}, x - 1, 2, 8'h00);
      check_pixel({name, "_left_in"}, x, 2, col_rgb(col));
      check_pixel({name, "_right_in"}, x + 63, 2, col_rgb(col));
      if (x + 64 < 640) check_pixel({name, "_right_out"}, x + 64, 2, 8'h00);
   endtask

   task automatic press(input logic r, input logic l, input logic m, input logic t,
                        input int hold);
      @(negedge clk);
      btnR = r;
      btnL = l;
      btnM = m;
      btnT = t;
      repeat (hold) @(negedge clk);
      btnR = 1'b0;
      btnL = 1'b0;
      btnM = 1'b0;
      btnT = 1'b0;
      repeat (40) @(negedge clk);
   endtask

   initial begin
      vecs[0]  = '{r: 1, l: 0, m: 0, t: 0, x: 304, col: 0};
      vecs[1]  = '{r: 0, l: 0, m: 0, t: 1, x: 304, col: 1};
      vecs[2]  = '{r: 0, l: 1, m: 0, t: 0, x: 288, col: 1};
      vecs[3]  = '{r: 1, l: 1, m: 0, t: 0, x: 288, col: 1};
      vecs[4]  = '{r: 0, l: 0, m: 0, t: 1, x: 288, col: 2};
      vecs[5]  = '{r: 1, l: 0, m: 0, t: 1, x: 304, col: 3};
      vecs[6]  = '{r: 0, l: 0, m: 0, t: 1, x: 304, col: 0};
      vecs[7]  = '{r: 0, l: 1, m: 0, t: 0, x: 288, col: 0};
      vecs[8]  = '{r: 1, l: 0, m: 1, t: 0, x: 288, col: 0};
      vecs[9]  = '{r: 0, l: 1, m: 0, t: 0, x: 272, col: 0};
      vecs[10] = '{r: 0, l: 0, m: 1, t: 0, x: 288, col: 0};
      vecs[11] = '{r: 0, l: 1, m: 0, t: 1, x: 272, col: 1};
      vecs[12] = '{r: 0, l: 0, m: 1, t: 0, x: 288, col: 1};

      btnR = 1'b0;
      btnL = 1'b0;
      btnM = 1'b0;
      btnT = 1'b0;
      sw   = 1'b1;
      #2 sw = 1'b0;
      repeat (50) @(negedge clk);
      chk("reset_hsync", Hsync, 1);
      chk("reset_vsync", Vsync, 1);
      chk("reset_rgb", rgb, 0);
      repeat (50) @(negedge clk);
      sw = 1'b1;
      counting = 1;

      wait_edge(2624);
      chk("hsync_before_fall", Hsync, 1);
      chk("vsync_line0", Vsync, 1);
      wait_edge(2625);
      chk("hsync_first_fall", Hsync, 0);
      wait_edge(3008);
      chk("hsync_last_low", Hsync, 0);
      wait_edge(3009);
      chk("hsync_rise", Hsync, 1);
      check_pixel("row_above_box", 300, 1, 8'h00);
      wait_edge(5824);
      chk("hsync_line1_before_fall", Hsync, 1);
      wait_edge(5825);
      chk("hsync_line1_fall", Hsync, 0);
      check_box("reset_box", 288, 0);

`ifdef DRIVER_DEBOUNCE_EN
      for (int rep = 0; rep < 10; rep++) begin
         for (int i = 0; i < 18; i++) #3 btnR = ~btnR;
         for (int i = 0; i < 20; i++) #3 btnL = ~btnL;
      end
      repeat (40) @(negedge clk);
      check_box("glitch", 288, 0);
`endif

      for (int i = 0; i < 13; i++) begin
         press(vecs[i].r, vecs[i].l, vecs[i].m, vecs[i].t, 40);
         check_box($sformatf("vec%0d", i), vecs[i].x, vecs[i].col);
      end

      for (int i = 0; i < 40; i++) press(1, 0, 0, 0, 20);
      check_box("sat_right", 576, 1);
      for (int i = 0; i < 40; i++) press(0, 1, 0, 0, 20);
      check_box("sat_left", 0, 1);
      press(0, 0, 1, 0, 20);
      check_box("centre", 288, 1);

      press(1, 0, 0, 0, 200);
      check_box("held_once", 304, 1);
      press(1, 0, 0, 0, 20);
      check_box("repress", 320, 1);

      check_pixel("mid_frame_in_box", 330, 2, col_rgb(1));
      #1 sw = 1'b0;
      #1;
      chk("mid_reset_rgb", rgb, 0);
      chk("mid_reset_hsync", Hsync, 1);
      chk("mid_reset_vsync", Vsync, 1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
